// File: rtl/cnn_accel_ahb_regif.sv
// AHB-Lite control/status register file for the CNN accelerator: configuration, start pulses, sticky done flags.
// Optional interrupt output and IRQ_CTRL register at 0x24 when CNN_ACCEL_IRQ_EN is defined.
module cnn_accel_ahb_regif #(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int W_SIZE  = 12,
    parameter int W_FRAME = 25
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [W_ADDR-1:0]  HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [W_DATA-1:0]  HWDATA,
    input  logic               HREADY,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic [W_DATA-1:0]  HRDATA,
    output logic [W_FRAME-1:0] frame_size,
    output logic [W_SIZE-1:0]  width,
    output logic [W_SIZE-1:0]  height,
    output logic [W_SIZE-1:0]  start_delay,
    output logic [W_SIZE-1:0]  hsync_delay,
    output logic [19:0]        base_weight,
    output logic [11:0]        base_param,
    output logic [15:0]        layer_config,
    output logic [W_ADDR-1:0]  img_base,
    output logic               layer_start,
    input  logic               layer_done_i,
    output logic               img_load,
    input  logic               img_done_i
`ifdef CNN_ACCEL_IRQ_EN
    ,
    output logic               irq
`endif
);

    localparam logic [3:0] A_FRAME  = 4'h0;
    localparam logic [3:0] A_WH     = 4'h1;
    localparam logic [3:0] A_DELAY  = 4'h2;
    localparam logic [3:0] A_BASE   = 4'h3;
    localparam logic [3:0] A_LCFG   = 4'h4;
    localparam logic [3:0] A_LSTART = 4'h5;
    localparam logic [3:0] A_LDONE  = 4'h6;
    localparam logic [3:0] A_IMGB   = 4'h7;
    localparam logic [3:0] A_IMGLD  = 4'h8;
`ifdef CNN_ACCEL_IRQ_EN
    localparam logic [3:0] A_IRQ    = 4'h9;
`endif

    logic               r_dp_valid;
    logic               r_dp_write;
    logic [3:0]         r_dp_addr;
    logic [W_FRAME-1:0] r_frame;
    logic [W_SIZE-1:0]  r_width;
    logic [W_SIZE-1:0]  r_height;
    logic [W_SIZE-1:0]  r_start_delay;
    logic [W_SIZE-1:0]  r_hsync_delay;
    logic [19:0]        r_base_weight;
    logic [11:0]        r_base_param;
    logic [15:0]        r_layer_cfg;
    logic [W_ADDR-1:0]  r_img_base;
    logic               r_layer_go;
    logic               r_img_go;
    logic               r_layer_start;
    logic               r_img_load;
    logic               r_layer_done;
    logic               r_img_done;
    logic [W_DATA-1:0]  w_rdata;
    logic               w_addr_valid;
    logic               w_wr_en;
    logic               w_unused;

    assign w_addr_valid = HSEL & HREADY & HTRANS[1];
    assign w_wr_en      = r_dp_valid & r_dp_write;
    assign w_unused     = ^{HADDR[W_ADDR-1:6], HADDR[1:0], HTRANS[0]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 4'h0;
        end else begin
            r_dp_valid <= w_addr_valid;
            if (w_addr_valid) begin
                r_dp_write <= HWRITE;
                r_dp_addr  <= HADDR[5:2];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_frame       <= '0;
            r_width       <= '0;
            r_height      <= '0;
            r_start_delay <= '0;
            r_hsync_delay <= '0;
            r_base_weight <= '0;
            r_base_param  <= '0;
            r_layer_cfg   <= '0;
            r_img_base    <= '0;
        end else if (w_wr_en) begin
            case (r_dp_addr)
                A_FRAME: r_frame <= HWDATA[W_FRAME-1:0];
                A_WH: begin
                    r_width  <= HWDATA[W_SIZE-1:0];
                    r_height <= HWDATA[16+W_SIZE-1:16];
                end
                A_DELAY: begin
                    r_start_delay <= HWDATA[W_SIZE-1:0];
                    r_hsync_delay <= HWDATA[2*W_SIZE-1:W_SIZE];
                end
                A_BASE: begin
                    r_base_weight <= HWDATA[19:0];
                    r_base_param  <= HWDATA[31:20];
                end
                A_LCFG:  r_layer_cfg <= HWDATA[15:0];
                A_IMGB:  r_img_base  <= HWDATA[W_ADDR-1:0];
                default: ;
            endcase
        end
    end

    // Pulses fire only on a 0->1 transition of the last written start bit.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_layer_go    <= 1'b0;
            r_img_go      <= 1'b0;
            r_layer_start <= 1'b0;
            r_img_load    <= 1'b0;
        end else begin
            r_layer_start <= 1'b0;
            r_img_load    <= 1'b0;
            if (w_wr_en && r_dp_addr == A_LSTART) begin
                r_layer_go    <= HWDATA[0];
                r_layer_start <= HWDATA[0] & ~r_layer_go;
            end
            if (w_wr_en && r_dp_addr == A_IMGLD) begin
                r_img_go   <= HWDATA[0];
                r_img_load <= HWDATA[0] & ~r_img_go;
            end
        end
    end

    // Done flags: a new done event beats the clearing start pulse.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_layer_done <= 1'b0;
            r_img_done   <= 1'b0;
        end else begin
            if (layer_done_i)       r_layer_done <= 1'b1;
            else if (r_layer_start) r_layer_done <= 1'b0;
            if (img_done_i)         r_img_done   <= 1'b1;
            else if (r_img_load)    r_img_done   <= 1'b0;
        end
    end

`ifdef CNN_ACCEL_IRQ_EN
    logic [1:0] r_irq_mask;
    logic       r_irq;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_irq_mask <= 2'b00;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_en && r_dp_addr == A_IRQ) r_irq_mask <= HWDATA[1:0];
            r_irq <= |(r_irq_mask & {r_img_done, r_layer_done});
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_rdata = '0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                A_FRAME: w_rdata = {{(W_DATA-W_FRAME){1'b0}}, r_frame};
                A_WH:    w_rdata = {{(W_DATA-16-W_SIZE){1'b0}}, r_height, {(16-W_SIZE){1'b0}}, r_width};
                A_DELAY: w_rdata = {{(W_DATA-2*W_SIZE){1'b0}}, r_hsync_delay, r_start_delay};
                A_BASE:  w_rdata = {r_base_param, r_base_weight};
                A_LCFG:  w_rdata = {{(W_DATA-16){1'b0}}, r_layer_cfg};
                A_LDONE: w_rdata = {{(W_DATA-1){1'b0}}, r_layer_done};
                A_IMGB:  w_rdata = r_img_base;
                A_IMGLD: w_rdata = {{(W_DATA-1){1'b0}}, r_img_done};
`ifdef CNN_ACCEL_IRQ_EN
                A_IRQ:   w_rdata = {{(W_DATA-2){1'b0}}, r_irq_mask};
`endif
                default: w_rdata = '0;
            endcase
        end
    end

    assign HRDATA       = w_rdata;
    assign HREADYOUT    = 1'b1;
    assign HRESP        = 1'b0;
    assign frame_size   = r_frame;
    assign width        = r_width;
    assign height       = r_height;
    assign start_delay  = r_start_delay;
    assign hsync_delay  = r_hsync_delay;
    assign base_weight  = r_base_weight;
    assign base_param   = r_base_param;
    assign layer_config = r_layer_cfg;
    assign img_base     = r_img_base;
    assign layer_start  = r_layer_start;
    assign img_load     = r_img_load;

endmodule

// File: tb/tb_cnn_accel_ahb_regif.sv
// Bench for cnn_accel_ahb_regif: pipelined AHB driver with a read scoreboard, pulse monitors and flag checks.
module tb_cnn_accel_ahb_regif;

    logic        clk = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic [24:0] frame_size;
    logic [11:0] width, height, start_delay, hsync_delay;
    logic [19:0] base_weight;
    logic [11:0] base_param;
    logic [15:0] layer_config;
    logic [31:0] img_base;
    logic        layer_start, img_load;
    logic        layer_done_i = 1'b0;
    logic        img_done_i = 1'b0;
`ifdef CNN_ACCEL_IRQ_EN
    logic        irq;
`endif

    cnn_accel_ahb_regif dut (
        .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .HRDATA(HRDATA), .frame_size(frame_size), .width(width),
        .height(height), .start_delay(start_delay), .hsync_delay(hsync_delay),
        .base_weight(base_weight), .base_param(base_param), .layer_config(layer_config),
        .img_base(img_base), .layer_start(layer_start), .layer_done_i(layer_done_i),
        .img_load(img_load), .img_done_i(img_done_i)
`ifdef CNN_ACCEL_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        dp_read = 1'b0;
    logic [31:0] dp_wdata = '0;
    int          ls_rise = 0, ls_wide = 0, il_rise = 0, il_wide = 0, bus_viol = 0;
    logic        ls_prev = 1'b0, il_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Pulse-width and bus-response monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (layer_start) begin
            if (ls_prev) ls_wide++;
            else ls_rise++;
        end
        if (img_load) begin
            if (il_prev) il_wide++;
            else il_rise++;
        end
        ls_prev = layer_start;
        il_prev = img_load;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) bus_viol++;
    end

    // One bus cycle: compare any read completing now, drive the next address phase,
    // supply write data for the previous one, and queue the expected read result.
    task automatic bus(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
        sb_t e;
        if (dp_read) begin
            e = sb_q.pop_front();
            check_val($sformatf("rd_%02h", e.addr), HRDATA, e.data);
        end
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HWDATA = dp_wdata;
        dp_read  = sel && trans[1] && !wr;
        dp_wdata = wdata;
        if (dp_read) begin
            e.addr = addr;
            e.data = exp;
            sb_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b1, 2'b10, 1'b1, a, d, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        bus(1'b1, 2'b10, 1'b0, a, 32'h0, e);
    endtask

    task automatic idle();
        bus(1'b1, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check_val("rst_frame", {7'h0, frame_size}, 32'h0);
        check_val("rst_lstart", {31'h0, layer_start}, 32'h0);
        check_val("rst_hrdata", HRDATA, 32'h0);
        check_val("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        HRESET = 1'b0;
        idle();

        wr(32'h00, 32'd16384);
        rd(32'h00, 32'h0000_4000);
        idle();
        check_val("frame_size", {7'h0, frame_size}, 32'd16384);
        check_val("hrdata_idle", HRDATA, 32'h0);

        wr(32'h04, 32'h0080_0080);
        wr(32'h10, 32'h0000_3071);
        rd(32'h04, 32'h0080_0080);
        rd(32'h10, 32'h0000_3071);
        idle();
        check_val("width", {20'h0, width}, 32'd128);
        check_val("height", {20'h0, height}, 32'd128);
        check_val("layer_config", {16'h0, layer_config}, 32'h3071);

        wr(32'h04, 32'hFFFF_FFFF);
        rd(32'h04, 32'h0FFF_0FFF);
        wr(32'h08, 32'hFFFF_FFFF);
        rd(32'h08, 32'h00FF_FFFF);
        wr(32'h00, 32'hFFFF_FFFF);
        rd(32'h00, 32'h01FF_FFFF);
        wr(32'h08, 32'h00AB_C123);
        idle();
        check_val("start_delay", {20'h0, start_delay}, 32'h123);
        check_val("hsync_delay", {20'h0, hsync_delay}, 32'hABC);

        wr(32'h0C, 32'hABC1_2345);
        rd(32'h0C, 32'hABC1_2345);
        rd(32'h30, 32'h0);
        idle();
        check_val("base_weight", {12'h0, base_weight}, 32'h1_2345);
        check_val("base_param", {20'h0, base_param}, 32'hABC);

        bus(1'b1, 2'b00, 1'b1, 32'h1C, 32'h1111_1111, 32'h0);
        bus(1'b0, 2'b10, 1'b1, 32'h1C, 32'h2222_2222, 32'h0);
        idle();
        rd(32'h1C, 32'h0);
        wr(32'h1C, 32'h8000_0004);
        rd(32'h1C, 32'h8000_0004);
        idle();
        check_val("img_base", img_base, 32'h8000_0004);

`ifndef CNN_ACCEL_IRQ_EN
        wr(32'h24, 32'h3);
        rd(32'h24, 32'h0);
        idle();
`endif

        base = ls_rise;
        wr(32'h14, 32'h1);
        idle();
        check_val("lstart_lat", {31'h0, layer_start}, 32'h1);
        wr(32'h14, 32'h1);
        wr(32'h14, 32'h0);
        wr(32'h14, 32'h1);
        repeat (3) idle();
        check_val("lstart_count", ls_rise - base, 32'd2);

        layer_done_i = 1'b1;
        idle();
        layer_done_i = 1'b0;
        rd(32'h18, 32'h1);
        rd(32'h18, 32'h1);
        wr(32'h18, 32'h0);
        rd(32'h18, 32'h1);
        wr(32'h14, 32'h0);
        wr(32'h14, 32'h1);
        idle();
        idle();
        rd(32'h18, 32'h0);
        wr(32'h14, 32'h0);
        wr(32'h14, 32'h1);
        idle();
        check_val("lstart_coinc", {31'h0, layer_start}, 32'h1);
        layer_done_i = 1'b1;
        idle();
        layer_done_i = 1'b0;
        rd(32'h18, 32'h1);
        idle();

        base = il_rise;
        wr(32'h20, 32'h1);
        idle();
        check_val("imgload_lat", {31'h0, img_load}, 32'h1);
        idle();
        check_val("imgload_off", {31'h0, img_load}, 32'h0);
        img_done_i = 1'b1;
        idle();
        img_done_i = 1'b0;
        rd(32'h20, 32'h1);
        wr(32'h20, 32'h1);
        wr(32'h20, 32'h0);
        wr(32'h20, 32'h1);
        idle();
        idle();
        rd(32'h20, 32'h0);
        idle();
        check_val("imgload_count", il_rise - base, 32'd2);

`ifdef CNN_ACCEL_IRQ_EN
        wr(32'h24, 32'h1);
        rd(32'h24, 32'h1);
        idle();
        layer_done_i = 1'b1;
        idle();
        layer_done_i = 1'b0;
        idle();
        check_val("irq_set", {31'h0, irq}, 32'h1);
        wr(32'h14, 32'h0);
        wr(32'h14, 32'h1);
        repeat (4) idle();
        check_val("irq_clr", {31'h0, irq}, 32'h0);
        wr(32'h24, 32'h0);
        idle();
        layer_done_i = 1'b1;
        idle();
        layer_done_i = 1'b0;
        repeat (3) idle();
        check_val("irq_masked", {31'h0, irq}, 32'h0);
`endif

        wr(32'h1C, 32'hDEAD_BEEF);
        HRESET = 1'b1;
        idle();
        HRESET = 1'b0;
        idle();
        rd(32'h1C, 32'h0);
        rd(32'h18, 32'h0);
        rd(32'h04, 32'h0);
        idle();
        check_val("rst_img_base", img_base, 32'h0);

        check_val("lstart_width", ls_wide, 32'd0);
        check_val("imgload_width", il_wide, 32'd0);
        check_val("bus_resp", bus_viol, 32'd0);
        check_val("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
